alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - Registered 32-bit integer ALU: two 32-bit unsigned operands, 3-bit opcode, 64-bit result,
//   plus carry and zero flags.
// - Datapath leaf block feeding the register-file write-back path; no handshake.
// - Computes one new result every clock cycle.
// PARAMETERS
// - none (widths fixed: operands 32, result 64, opcode 3)
// PORTS
// - clk       input   1   single clock; all state updates on rising edge
// - rst_n     input   1   reset, asynchronous, active-low
// - opcode    input   3   operation select (table below)
// - operand1  input  32   operand A, unsigned
// - operand2  input  32   operand B, unsigned
// - result    output 64   registered operation result
// - flagc     output  1   registered carry/borrow/overflow flag
// - flagz     output  1   registered zero flag: 1 when the result being loaded is all zeros
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - rst_n low: result=64'h0, flagc=0, flagz=1 immediately, independent of clk; held while low.
// - After rst_n rises, the first rising clk edge loads the result of the current inputs.
// - Latency 1 cycle: opcode/operand1/operand2 sampled at rising clk.
//   - result/flagc/flagz for those inputs are valid after that edge and held until the next edge.
// - All operations are evaluated combinationally and then registered.
// - Operation table (A=operand1, B=operand2, all unsigned):
//   - 000 ADD: result = {31'b0, A+B (33-bit)}; flagc = carry out (result[32])
//   - 001 SUB: result = {32'b0, (A-B) mod 2^32}; flagc = borrow (1 iff A<B)
//   - 010 MUL: result = A*B full 64-bit product; flagc = |product[63:32]
//   - 011 DIV: result = {A%B, A/B} (remainder upper word, quotient lower); flagc=0
//     - B==0: quotient=32'hFFFF_FFFF, remainder=A, flagc=1
//   - 100 AND: result = {32'b0, A&B}; flagc=0
//   - 101 OR : result = {32'b0, A|B}; flagc=0
//   - 110 XOR: result = {32'b0, A^B}; flagc=0
//   - 111 SHL: result = {32'b0,A} << B[5:0] (64-bit logical, zero fill); flagc=0
//     - B[31:6] ignored; shift amount 0..63
// - flagz = (next result == 64'h0); computed on the full 64-bit result; independent of flagc.
// - X/Z on inputs are not handled; inputs are assumed driven whenever clk rises.
// - Boundaries:
//   - ADD FFFF_FFFF+1 -> result 64'h1_0000_0000, flagc=1, flagz=0
//   - SUB equal operands -> result 0, flagc=0, flagz=1
//   - MUL FFFF_FFFF*FFFF_FFFF -> 64'hFFFF_FFFE_0000_0001, flagc=1
//   - DIV by zero as above; SHL by 63 keeps only A[0] at bit 63
// - Reset asserted mid-stream: outputs go to reset values at once.
//   - No pending result is retained or emitted after release.
// TESTING
// - Reset: drive rst_n=0 between clk edges
//   -> result=0, flagc=0, flagz=1 without a clk edge; outputs hold while low.
// - Sweep, A=2, B=3, opcodes 0..7, one per cycle; each value 1 cycle after applied:
//   - ADD: 64'h5
//   - SUB: 64'h0000_0000_FFFF_FFFF with flagc=1
//   - MUL: 64'h6
//   - DIV: 64'h0000_0002_0000_0000
//   - AND: 64'h2
//   - OR: 64'h3
//   - XOR: 64'h1
//   - SHL: 64'h10
//   - flagz=0 for all eight.
// - Carry/overflow:
//   - ADD FFFF_FFFF+1 -> 64'h1_0000_0000, flagc=1
//   - MUL 1_0000*1_0000 -> 64'h1_0000_0000, flagc=1
// - Zero flag:
//   - SUB 7-7 -> 0, flagz=1
//   - AND F0F0_F0F0 & 0F0F_0F0F -> 0, flagz=1
//   - XOR A,A -> 0, flagz=1
// - Divide:
//   - 100/7 -> 64'h0000_0002_0000_000E
//   - 5/0 -> 64'h0000_0005_FFFF_FFFF, flagc=1
// - Latency: change opcode every cycle, random A/B for 1000 cycles;
//   - result/flags must equal the reference model of the previous-cycle inputs.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read stage and the ALU.
// The ALU itself has no handshake: a new operation is presented every cycle.
interface alu_if;
    logic [2:0]  opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [63:0] result;
    logic        flagc;
    logic        flagz;

    // Issuing side: drives the operation, observes the registered result.
    modport master (
        output opcode,
        output operand1,
        output operand2,
        input  result,
        input  flagc,
        input  flagz
    );

    // ALU side: samples the operation, returns the registered result.
    modport slave (
        input  opcode,
        input  operand1,
        input  operand2,
        output result,
        output flagc,
        output flagz
    );
endinterface

// File: rtl/alu.sv
// Registered 32-bit integer ALU with a 64-bit result and carry/zero flags.
// All eight operations are evaluated combinationally from the live inputs and
// the selected one is captured on every rising clock edge (one-cycle latency).
module alu (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_SHL = 3'b111
    } op_e;

    logic [63:0] result_d;
    logic [63:0] result_q;
    logic        flagc_d;
    logic        flagc_q;
    logic        flagz_d;
    logic        flagz_q;

    // 33-bit sum; bit 32 is the carry out and lands in the result as well.
    function automatic logic [32:0] add_full(input logic [31:0] a, input logic [31:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Restoring unsigned divider, one quotient bit per iteration, MSB first.
    // Returns {remainder, quotient}. A zero divisor is reported separately by
    // the caller, which substitutes the all-ones quotient and passes A through.
    function automatic logic [63:0] udivmod(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] trial;
        logic [31:0] rem;
        logic [31:0] quo;
        rem = '0;
        quo = a;
        for (int i = 0; i < 32; i++) begin
            trial = {rem, quo[31]};
            quo   = {quo[30:0], 1'b0};
            if (trial >= {1'b0, b}) begin
                rem    = 32'(trial - {1'b0, b});
                quo[0] = 1'b1;
            end else begin
                rem = trial[31:0];
            end
        end
        return {rem, quo};
    endfunction

    // 64-bit logical left shift of the zero-extended operand; only the low six
    // bits of the shift amount matter so shifts range over 0..63.
    function automatic logic [63:0] shl64(input logic [31:0] a, input logic [5:0] sh);
        return {32'b0, a} << sh;
    endfunction

    // Next-state selection of result and carry; zero flag derives from the full result.
    always_comb begin
        logic [32:0] sum;
        logic [63:0] prod;
        logic [63:0] qr;
        result_d = '0;
        flagc_d  = 1'b0;
        sum      = add_full(bus.operand1, bus.operand2);
        prod     = 64'(bus.operand1) * 64'(bus.operand2);
        qr       = udivmod(bus.operand1, bus.operand2);
        case (op_e'(bus.opcode))
            OP_ADD: begin
                result_d = {31'b0, sum};
                flagc_d  = sum[32];
            end
            OP_SUB: begin
                result_d = {32'b0, bus.operand1 - bus.operand2};
                flagc_d  = (bus.operand1 < bus.operand2);
            end
            OP_MUL: begin
                result_d = prod;
                flagc_d  = |prod[63:32];
            end
            OP_DIV: begin
                if (bus.operand2 == 32'h0) begin
                    result_d = {bus.operand1, 32'hFFFF_FFFF};
                    flagc_d  = 1'b1;
                end else begin
                    result_d = qr;
                end
            end
            OP_AND: result_d = {32'b0, bus.operand1 & bus.operand2};
            OP_OR:  result_d = {32'b0, bus.operand1 | bus.operand2};
            OP_XOR: result_d = {32'b0, bus.operand1 ^ bus.operand2};
            OP_SHL: result_d = shl64(bus.operand1, bus.operand2[5:0]);
            default: begin
                result_d = '0;
                flagc_d  = 1'b0;
            end
        endcase
        flagz_d = (result_d == 64'h0);
    end

    // Output register; reset clears the result immediately and drops any pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 64'h0;
            flagc_q  <= 1'b0;
            flagz_q  <= 1'b1;
        end else begin
            result_q <= result_d;
            flagc_q  <= flagc_d;
            flagz_q  <= flagz_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flagc  = flagc_q;
    assign bus.flagz  = flagz_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the registered ALU: reset behaviour, opcode sweep,
// carry/zero/divide boundaries, mid-stream reset and a randomised latency run.
module tb_alu;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   fails;

    alu_if u_if ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] r, input logic c, input logic z);
        chk({tag, ".result"}, u_if.result, r);
        chk({tag, ".flagc"}, {63'b0, u_if.flagc}, {63'b0, c});
        chk({tag, ".flagz"}, {63'b0, u_if.flagz}, {63'b0, z});
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.opcode   = op;
        u_if.operand1 = a;
        u_if.operand2 = b;
    endtask

    // Apply inputs, let one rising edge capture them, sample 1 time unit later.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        @(posedge clk);
        #1;
    endtask

    // Independent reference: {flagc, result}.
    function automatic logic [64:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] r;
        logic        c;
        r = '0;
        c = 1'b0;
        case (op)
            3'd0: begin r = 64'(a) + 64'(b); c = r[32]; end
            3'd1: begin r = {32'b0, a - b}; c = (a < b); end
            3'd2: begin r = 64'(a) * 64'(b); c = (r[63:32] != 0); end
            3'd3: begin
                if (b == 0) begin r = {a, 32'hFFFF_FFFF}; c = 1'b1; end
                else        r = {a % b, a / b};
            end
            3'd4: r = {32'b0, a & b};
            3'd5: r = {32'b0, a | b};
            3'd6: r = {32'b0, a ^ b};
            default: r = 64'(a) << b[5:0];
        endcase
        return {c, r};
    endfunction

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] m;
        logic [63:0] sweep_exp [8];
        total  = 0;
        passed = 0;
        fails  = 0;

        // Reset asserted between edges takes effect with no clock edge.
        rst_n = 1'b1;
        drive(3'd0, 32'd2, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset_async", 64'h0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("reset_hold", 64'h0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Opcode sweep with A=2, B=3.
        sweep_exp[0] = 64'h5;
        sweep_exp[1] = 64'h0000_0000_FFFF_FFFF;
        sweep_exp[2] = 64'h6;
        sweep_exp[3] = 64'h0000_0002_0000_0000;
        sweep_exp[4] = 64'h2;
        sweep_exp[5] = 64'h3;
        sweep_exp[6] = 64'h1;
        sweep_exp[7] = 64'h10;
        for (int i = 0; i < 8; i++) begin
            step(3'(i), 32'd2, 32'd3);
            chk_out($sformatf("sweep_op%0d", i), sweep_exp[i], (i == 1), 1'b0);
        end

        // Carry / overflow.
        step(3'd0, 32'hFFFF_FFFF, 32'h1);
        chk_out("add_carry", 64'h1_0000_0000, 1'b1, 1'b0);
        step(3'd2, 32'h1_0000, 32'h1_0000);
        chk_out("mul_ovf", 64'h1_0000_0000, 1'b1, 1'b0);
        step(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_out("mul_max", 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);

        // Zero flag.
        step(3'd1, 32'd7, 32'd7);
        chk_out("sub_zero", 64'h0, 1'b0, 1'b1);
        step(3'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        chk_out("and_zero", 64'h0, 1'b0, 1'b1);
        step(3'd6, 32'h1234_5678, 32'h1234_5678);
        chk_out("xor_zero", 64'h0, 1'b0, 1'b1);

        // Divide.
        step(3'd3, 32'd100, 32'd7);
        chk_out("div_100_7", 64'h0000_0002_0000_000E, 1'b0, 1'b0);
        step(3'd3, 32'd5, 32'd0);
        chk_out("div_by_0", 64'h0000_0005_FFFF_FFFF, 1'b1, 1'b0);
        step(3'd3, 32'hFFFF_FFFF, 32'd1);
        chk_out("div_by_1", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);

        // Shift boundaries: 63 keeps only A[0]; upper shift bits ignored.
        step(3'd7, 32'hFFFF_FFFF, 32'd63);
        chk_out("shl_63", 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        step(3'd7, 32'hDEAD_BEEF, 32'h0000_0040);
        chk_out("shl_wrap", 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        step(3'd7, 32'h2, 32'd63);
        chk_out("shl_lost", 64'h0, 1'b0, 1'b1);

        // Mid-stream reset: outputs clear at once; no stale result after release.
        step(3'd2, 32'd9, 32'd9);
        chk_out("pre_reset", 64'd81, 1'b0, 1'b0);
        drive(3'd0, 32'd1, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 64'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_out("post_reset", 64'h2, 1'b0, 1'b0);

        // Latency run: opcode changes every cycle, random operands.
        op = 3'd0;
        for (int i = 0; i < 1000; i++) begin
            op = 3'(op + 3'(1 + $urandom_range(0, 6)));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            m  = ref_alu(op, a, b);
            step(op, a, b);
            chk_out($sformatf("rand%0d_op%0d", i, op), m[63:0], m[64], (m[63:0] == 64'h0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
